// File: rtl/spi_sram_responder.sv
// Target side of a 23LC1024-style SPI/SQI serial SRAM link, serving RSTIO/EQIO/READ/WRITE
// from a byte-wide memory port. sram_sck is oversampled on clk through a synchronizer.
module spi_sram_responder #(
    parameter int MEM_ADDRESS_WIDTH = 17,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sram_cs_n,
    input  logic                         sram_sck,
    input  logic [3:0]                   sram_sio_i,
    output logic [3:0]                   sram_sio_o,
    output logic                         sram_sio_oe,
    output logic                         sqi_mode,
    output logic                         busy,
    output logic [MEM_ADDRESS_WIDTH-1:0] mem_addr,
    output logic [7:0]                   mem_wdata,
    output logic                         mem_we,
    output logic                         mem_re,
    input  logic [7:0]                   mem_rdata
);
    localparam int AW = MEM_ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_INSTR, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
    } state_t;

    // Bundle {cs_n, sck, sio[3:0]} so all serial inputs see identical latency.
    logic [5:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 6'b100000;
        end else begin
            sync_q[0] <= {sram_cs_n, sram_sck, sram_sio_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    logic       cs_s, sck_s, rise, fall;
    logic [3:0] sio_s;

    state_t          state_q, state_d;
    logic            sqi_mode_q, sqi_mode_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            is_read_q, is_read_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic            mem_re_q, mem_re_d;
    logic            rd_cap_q, rd_cap_d;
    logic [7:0]      prefetch_q, prefetch_d;
    logic [7:0]      out_byte_q, out_byte_d;
    logic            low_next_q, low_next_d;
    logic [3:0]      sio_o_q, sio_o_d;
    logic            sio_oe_q, sio_oe_d;
    logic            busy_q, busy_d;
    logic            sck_prev_q, sck_prev_d;

    assign cs_s  = sync_q[SYNC_STAGES-1][5];
    assign sck_s = sync_q[SYNC_STAGES-1][4];
    assign sio_s = sync_q[SYNC_STAGES-1][3:0];
    assign rise  = sck_s & ~sck_prev_q;
    assign fall  = ~sck_s & sck_prev_q;

    always_comb begin
        state_d     = state_q;
        sqi_mode_d  = sqi_mode_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        is_read_d   = is_read_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        rd_cap_d    = mem_re_q;
        prefetch_d  = rd_cap_q ? mem_rdata : prefetch_q;
        out_byte_d  = out_byte_q;
        low_next_d  = low_next_q;
        sio_o_d     = sio_o_q;
        sio_oe_d    = sio_oe_q;
        busy_d      = ~cs_s;
        sck_prev_d  = sck_s;

        // The address advances the cycle after a write strobe so mem_we sees the target address.
        if (mem_we_q) mem_addr_d = mem_addr_q + AW'(1);

        if (cs_s) begin
            state_d  = S_IDLE;
            sio_oe_d = 1'b0;
            sio_o_d  = 4'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_INSTR;
                    shift_d = 8'h00;
                    cnt_d   = 3'd0;
                end
                S_INSTR: if (rise) begin
                    cnt_d = cnt_q + 3'd1;
                    if (!sqi_mode_q) begin
                        shift_d = {shift_q[6:0], sio_s[0]};
                        if (cnt_q == 3'd7) begin
                            if (shift_d == 8'h38) sqi_mode_d = 1'b1;
                            state_d = S_IGNORE;
                        end
                    end else begin
                        shift_d = {shift_q[3:0], sio_s};
                        if (cnt_q == 3'd1) begin
                            cnt_d = 3'd0;
                            case (shift_d)
                                8'h03: begin state_d = S_ADDR; is_read_d = 1'b1; end
                                8'h02: begin state_d = S_ADDR; is_read_d = 1'b0; end
                                8'hFF: begin state_d = S_IGNORE; sqi_mode_d = 1'b0; end
                                default: state_d = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: if (rise) begin
                    mem_addr_d = {mem_addr_q[AW-5:0], sio_s};
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        cnt_d = 3'd0;
                        if (is_read_q) begin
                            mem_re_d = 1'b1;
                            state_d  = S_DUMMY;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end
                end
                S_DUMMY: begin
                    if (rise && cnt_q < 3'd2) cnt_d = cnt_q + 3'd1;
                    if (fall && cnt_q == 3'd2) begin
                        out_byte_d = prefetch_q;
                        sio_o_d    = prefetch_q[7:4];
                        sio_oe_d   = 1'b1;
                        low_next_d = 1'b1;
                        state_d    = S_READ;
                    end
                end
                S_READ: if (fall) begin
                    if (low_next_q) begin
                        sio_o_d    = out_byte_q[3:0];
                        mem_addr_d = mem_addr_q + AW'(1);
                        mem_re_d   = 1'b1;
                        low_next_d = 1'b0;
                    end else begin
                        out_byte_d = prefetch_q;
                        sio_o_d    = prefetch_q[7:4];
                        low_next_d = 1'b1;
                    end
                end
                S_WRITE: if (rise) begin
                    if (!cnt_q[0]) begin
                        shift_d = {4'h0, sio_s};
                        cnt_d   = 3'd1;
                    end else begin
                        mem_wdata_d = {shift_q[3:0], sio_s};
                        mem_we_d    = 1'b1;
                        cnt_d       = 3'd0;
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sqi_mode_q  <= 1'b0;
            shift_q     <= 8'h00;
            cnt_q       <= 3'd0;
            is_read_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rd_cap_q    <= 1'b0;
            prefetch_q  <= 8'h00;
            out_byte_q  <= 8'h00;
            low_next_q  <= 1'b0;
            sio_o_q     <= 4'h0;
            sio_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            sck_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sqi_mode_q  <= sqi_mode_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            rd_cap_q    <= rd_cap_d;
            prefetch_q  <= prefetch_d;
            out_byte_q  <= out_byte_d;
            low_next_q  <= low_next_d;
            sio_o_q     <= sio_o_d;
            sio_oe_q    <= sio_oe_d;
            busy_q      <= busy_d;
            sck_prev_q  <= sck_prev_d;
        end
    end

    assign sram_sio_o  = sio_o_q;
    assign sram_sio_oe = sio_oe_q;
    assign sqi_mode    = sqi_mode_q;
    assign busy        = busy_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: a bus-functional SPI/SQI master drives transactions; memory
// strobes are checked against an expected-event queue by an independent monitor.
module tb_spi_sram_responder;
    localparam int AW   = 17;
    localparam int HALF = 6;
    localparam int W    = 1 + AW + 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sram_cs_n = 1'b1;
    logic          sram_sck = 1'b0;
    logic [3:0]    sram_sio_i = 4'h0;
    logic [3:0]    sram_sio_o;
    logic          sram_sio_oe;
    logic          sqi_mode;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [7:0]    mem_rdata = 8'h00;

    spi_sram_responder #(.MEM_ADDRESS_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sram_cs_n(sram_cs_n), .sram_sck(sram_sck),
        .sram_sio_i(sram_sio_i), .sram_sio_o(sram_sio_o), .sram_sio_oe(sram_sio_oe),
        .sqi_mode(sqi_mode), .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Backing memory: read data valid one clk after mem_re
    logic [7:0] mem [int];

    always @(posedge clk) begin
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
        if (mem_re) mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 8'h00;
    end

    // Scoreboard
    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    logic cmd_oe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ev(input bit we, input logic [23:0] addr, input logic [7:0] d);
        return {we, addr[AW-1:0], d};
    endfunction

    always @(negedge clk) begin
        if (reset_n && (mem_we || mem_re)) begin
            check("we_re_exclusive", {31'b0, mem_we & mem_re}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {6'b0, mem_we, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
            end else begin
                check("mem_strobe", {6'b0, mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00)},
                      {6'b0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cs_begin();
        sram_cs_n = 1'b0;
        cmd_oe    = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_end();
        wait_clks(HALF);
        sram_cs_n  = 1'b1;
        sram_sio_i = 4'h0;
        wait_clks(3 * HALF);
    endtask

    task automatic sqi_recv(output logic [3:0] q, output logic oe);
        sram_sio_i = 4'h0;
        wait_clks(HALF);
        sram_sck = 1'b1;
        q  = sram_sio_o;
        oe = sram_sio_oe;
        wait_clks(HALF);
        sram_sck = 1'b0;
    endtask

    task automatic sqi_send(input logic [3:0] d);
        sram_sio_i = d;
        wait_clks(HALF);
        sram_sck = 1'b1;
        cmd_oe   = cmd_oe | sram_sio_oe;
        wait_clks(HALF);
        sram_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sram_sio_i = {3'b000, b[i]};
            wait_clks(HALF);
            sram_sck = 1'b1;
            wait_clks(HALF);
            sram_sck = 1'b0;
        end
    endtask

    task automatic sqi_cmd(input logic [7:0] ins, input logic [23:0] a);
        sqi_send(ins[7:4]);
        sqi_send(ins[3:0]);
        for (int i = 5; i >= 0; i--) sqi_send(a[i*4 +: 4]);
    endtask

    task automatic sqi_write(input string name, input logic [23:0] a, input int nbytes,
                             input logic [15:0] wd);
        logic [15:0] sh;
        for (int k = 0; k < nbytes; k++) begin
            sh = wd >> (8 * (nbytes - 1 - k));
            exp_q.push_back(ev(1'b1, a + 24'(k), sh[7:0]));
        end
        cs_begin();
        sqi_cmd(8'h02, a);
        for (int i = 2 * nbytes - 1; i >= 0; i--) sqi_send(wd[i*4 +: 4]);
        cs_end();
        check({name, "_oe"}, {31'b0, cmd_oe}, 32'd0);
    endtask

    task automatic sqi_read(input string name, input logic [23:0] a, input int nbytes,
                            input logic [15:0] exp_data);
        logic [15:0] data;
        logic [3:0]  q;
        logic        oe;
        logic        oe_all;
        for (int k = 0; k <= nbytes; k++) exp_q.push_back(ev(1'b0, a + 24'(k), 8'h00));
        cs_begin();
        sqi_cmd(8'h03, a);
        sqi_send(4'h0);
        sqi_send(4'h0);
        check({name, "_oe_before_data"}, {31'b0, cmd_oe}, 32'd0);
        data   = 16'h0000;
        oe_all = 1'b1;
        for (int i = 0; i < 2 * nbytes; i++) begin
            sqi_recv(q, oe);
            data   = {data[11:0], q};
            oe_all = oe_all & oe;
        end
        check({name, "_oe_data"}, {31'b0, oe_all}, 32'd1);
        check({name, "_data"}, {16'h0, data}, {16'h0, exp_data});
        cs_end();
        check({name, "_oe_after_cs"}, {31'b0, sram_sio_oe}, 32'd0);
    endtask

    task automatic enter_sqi(input string name);
        cs_begin();
        sqi_send(4'hF);
        sqi_send(4'hF);
        cs_end();
        cs_begin();
        check({name, "_busy"}, {31'b0, busy}, 32'd1);
        spi_byte(8'h38);
        check({name, "_sqi_after_8th_rise"}, {31'b0, sqi_mode}, 32'd1);
        cs_end();
        check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
        check({name, "_sqi_kept"}, {31'b0, sqi_mode}, 32'd1);
    endtask

    // Stimulus
    initial begin
        logic [3:0] q;
        logic       oe;

        wait_clks(5);
        check("rst_sqi_mode", {31'b0, sqi_mode}, 32'd0);
        check("rst_sio_oe", {31'b0, sram_sio_oe}, 32'd0);
        check("rst_sio_o", {28'b0, sram_sio_o}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_addr", {15'b0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
        check("rst_strobes", {30'b0, mem_we, mem_re}, 32'd0);
        reset_n = 1'b1;
        wait_clks(5);

        enter_sqi("init");

        sqi_write("write_beef", 24'h002468, 2, 16'hBEEF);
        sqi_read("read_beef", 24'h002468, 2, 16'hBEEF);

        sqi_write("write_wrap", 24'h01FFFF, 2, 16'hA53C);
        sqi_read("read_wrap", 24'h01FFFF, 2, 16'hA53C);

        // Abort after three data nibbles: only the completed byte is written
        exp_q.push_back(ev(1'b1, 24'h000100, 8'h12));
        cs_begin();
        sqi_cmd(8'h02, 24'h000100);
        sqi_send(4'h1);
        sqi_send(4'h2);
        sqi_send(4'h3);
        cs_end();
        check("abort_oe", {31'b0, cmd_oe}, 32'd0);
        sqi_read("read_after_abort", 24'h000100, 1, 16'h0012);

        // Unimplemented SQI instructions (RDMR, EDIO) are ignored
        cs_begin();
        sqi_cmd(8'h05, 24'h000000);
        cs_end();
        cs_begin();
        sqi_cmd(8'h3B, 24'h000000);
        cs_end();
        check("unsupported_sqi_kept", {31'b0, sqi_mode}, 32'd1);

        // Asynchronous reset in the middle of a read data phase
        exp_q.push_back(ev(1'b0, 24'h002468, 8'h00));
        exp_q.push_back(ev(1'b0, 24'h002469, 8'h00));
        cs_begin();
        sqi_cmd(8'h03, 24'h002468);
        sqi_send(4'h0);
        sqi_send(4'h0);
        sqi_recv(q, oe);
        check("midread_first_nibble", {28'b0, q}, 32'hB);
        check("midread_oe", {31'b0, oe}, 32'd1);
        wait_clks(HALF);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_oe", {31'b0, sram_sio_oe}, 32'd0);
        check("async_rst_sqi", {31'b0, sqi_mode}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        sram_cs_n = 1'b1;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(5);

        // SPI-mode READ is not supported and must not touch memory
        cs_begin();
        spi_byte(8'h03);
        spi_byte(8'h00);
        cs_end();
        check("spi_read_ignored_sqi", {31'b0, sqi_mode}, 32'd0);

        // Re-enter SQI, then leave it with RSTIO
        enter_sqi("reinit");
        cs_begin();
        sqi_send(4'hF);
        sqi_send(4'hF);
        check("rstio_sqi_cleared", {31'b0, sqi_mode}, 32'd0);
        cs_end();
        check("rstio_sqi_idle", {31'b0, sqi_mode}, 32'd0);

        wait_clks(10);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
